div_request_dispatcher: RTL and testbench

//  Upstream feeder for the iterative divider. Buffers dividend/divisor requests
//  in a small FIFO and launches each into the divider with a 1-cycle

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_req_fifo.sv | 51 +++++
 rtl/div_request_dispatcher.sv | 129 ++++++++++++
 tb/tb_div_request_dispatcher.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types for the divider request dispatcher: FSM states, request and result records.
// Struct fields are sized by DIV_WIDTH/DIV_TAG_W, so the dispatcher's WIDTH/TAG_W must match them.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_TAG_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} dispatch_state_t;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
  } div_req_t;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 error;
    logic [DIV_TAG_W-1:0] tag;
  } div_res_t;
endpackage

// File: rtl/div_req_fifo.sv
// Synchronous request FIFO for the divider dispatcher; head is read combinationally.
// A push while full is refused even if a pop happens in the same cycle.
module div_req_fifo
  import div_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  div_req_t               wdata_i,
  input  logic                   pop_i,
  output div_req_t               rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  div_req_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/div_request_dispatcher.sv
// Feeds queued requests into the iterative divider one at a time and holds each tagged result
// until consumed. Optional WAIT watchdog with res_timeout port: define DIV_DISPATCH_TIMEOUT_EN.
module div_request_dispatcher
  import div_pkg::*;
#(
  parameter int WIDTH          = DIV_WIDTH,
  parameter int DEPTH          = 4,
  parameter int TAG_W          = DIV_TAG_W,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH-1:0]       req_dividend,
  input  logic [WIDTH-1:0]       req_divisor,
  output logic [WIDTH-1:0]       div_dividend,
  output logic [WIDTH-1:0]       div_divisor,
  output logic                   div_data_in_valid,
  input  logic                   div_busy,
  input  logic [WIDTH-1:0]       div_quotient,
  input  logic [WIDTH-1:0]       div_remainder,
  input  logic                   div_data_out_valid,
  input  logic                   div_error,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_quotient,
  output logic [WIDTH-1:0]       res_remainder,
  output logic                   res_error,
  output logic [TAG_W-1:0]       res_tag,
`ifdef DIV_DISPATCH_TIMEOUT_EN
  output logic                   res_timeout,
`endif
  output logic [$clog2(DEPTH):0] fifo_count
);
  dispatch_state_t state_q;
  div_req_t        push_req, head, launch_q;
  div_res_t        res_q;
  logic            res_valid_q, dv_q;
  logic            fifo_full, fifo_empty, launch;
  logic [TAG_W-1:0] tag_q, launch_tag_q;

  assign push_req  = '{dividend: req_dividend, divisor: req_divisor};
  assign req_ready = !rst && !fifo_full;
  // res_valid is always low in IDLE; kept in the term so the hold rule is explicit
  assign launch    = (state_q == IDLE) && !fifo_empty && !div_busy && !res_valid_q;

  div_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid && req_ready),
    .wdata_i (push_req),
    .pop_i   (launch),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef DIV_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt_q;
  logic          timeout_q;
  assign res_timeout = timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      launch_q     <= '0;
      dv_q         <= 1'b0;
      res_q        <= '0;
      res_valid_q  <= 1'b0;
      tag_q        <= '0;
      launch_tag_q <= '0;
`ifdef DIV_DISPATCH_TIMEOUT_EN
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        IDLE: if (launch) begin
          launch_q     <= head;
          dv_q         <= 1'b1;
          launch_tag_q <= tag_q;
          tag_q        <= tag_q + 1'b1;
          state_q      <= WAIT;
`ifdef DIV_DISPATCH_TIMEOUT_EN
          wait_cnt_q   <= '0;
`endif
        end
        // busy is not consulted here: the divider raises it a cycle after launch
        WAIT: if (div_data_out_valid) begin
          res_q <= '{quotient:  div_error ? '0 : div_quotient,
                     remainder: div_error ? '0 : div_remainder,
                     error:     div_error,
                     tag:       launch_tag_q};
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
`ifdef DIV_DISPATCH_TIMEOUT_EN
          timeout_q   <= 1'b0;
        end else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          res_q       <= '{quotient: '0, remainder: '0, error: 1'b1, tag: launch_tag_q};
          res_valid_q <= 1'b1;
          timeout_q   <= 1'b1;
          state_q     <= HOLD;
        end else begin
          wait_cnt_q  <= wait_cnt_q + 1'b1;
`endif
        end
        HOLD: if (res_ready) begin
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_dividend      = launch_q.dividend;
  assign div_divisor       = launch_q.divisor;
  assign div_data_in_valid = dv_q;
  assign res_valid         = res_valid_q;
  assign res_quotient      = res_q.quotient;
  assign res_remainder     = res_q.remainder;
  assign res_error         = res_q.error;
  assign res_tag           = res_q.tag;
endmodule

// File: tb/tb_div_request_dispatcher.sv
// Randomized bench for div_request_dispatcher with a behavioural divider and a queue-based
// reference model (request order, tag sequence, plain-arithmetic results).
module tb_div_request_dispatcher;
  localparam int W = 32, DEPTH = 4, TGW = 4, TO = 16;
`ifdef DIV_DISPATCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_ready;
  logic [W-1:0]  req_dividend = '0, req_divisor = '0;
  logic [W-1:0]  div_dividend, div_divisor;
  logic          div_data_in_valid;
  logic          div_busy = 1'b0;
  logic [W-1:0]  div_quotient = '0, div_remainder = '0;
  logic          div_data_out_valid = 1'b0, div_error = 1'b0;
  logic          res_valid, res_ready = 1'b0;
  logic [W-1:0]  res_quotient, res_remainder;
  logic          res_error;
  logic [TGW-1:0] res_tag;
  logic [2:0]    fifo_count;
`ifdef DIV_DISPATCH_TIMEOUT_EN
  logic          res_timeout;
`endif

  always #5 clk = ~clk;

  div_request_dispatcher #(.WIDTH(W), .DEPTH(DEPTH), .TAG_W(TGW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_data_in_valid(div_data_in_valid), .div_busy(div_busy),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_data_out_valid(div_data_out_valid), .div_error(div_error),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_quotient(res_quotient), .res_remainder(res_remainder),
    .res_error(res_error), .res_tag(res_tag),
`ifdef DIV_DISPATCH_TIMEOUT_EN
    .res_timeout(res_timeout),
`endif
    .fifo_count(fifo_count)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [W-1:0] a, b; int pstep; } req_e;
  typedef struct { logic [W-1:0] a, b; logic [TGW-1:0] tag; bit to; } fl_e;
  req_e fq[$];
  fl_e  iq[$];
  int   stepn = 0;
  logic [TGW-1:0] mtag = '0;

  bit dv_act = 0; int dv_cnt = 0; logic [W-1:0] dv_a, dv_b;
  int force_lat = 0;
  bit prev_dv = 0, prev_busy = 0, prev_resv = 0, prev_hold = 0, fired = 0;
  logic [W-1:0] pq, pr; logic pe; logic [TGW-1:0] pt;
  logic [W-1:0] last_q, last_r; logic last_e; logic [TGW-1:0] last_tag;

  // One clock cycle: observe outputs after the edge, drive inputs, resolve handshakes.
  task automatic cyc(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                     input bit rr, input bit r);
    req_e e; fl_e f;
    logic [W-1:0] eq, er; logic ee;
    @(posedge clk); #1;
    stepn++;
    if (div_data_in_valid) begin
      chk("busy_at_launch", prev_busy, 0);
      chk("pulse_width", prev_dv, 0);
      chk("launch_in_hold", prev_resv, 0);
      if (fq.size() == 0) chk("launch_unexpected", 1, 0);
      else begin
        e = fq.pop_front();
        chk("launch_a", div_dividend, e.a);
        chk("launch_b", div_divisor, e.b);
        chk("push_to_launch", (stepn - e.pstep) >= 2, 1);
        iq.push_back('{a: e.a, b: e.b, tag: mtag, to: TO_EN && (force_lat >= TO)});
        mtag++;
      end
    end
    prev_dv = div_data_in_valid;
    chk("fifo_count", fifo_count, fq.size());
    if (prev_hold) begin
      chk("hold_valid", res_valid, 1);
      chk("hold_q", res_quotient, pq);
      chk("hold_r", res_remainder, pr);
      chk("hold_e", res_error, pe);
      chk("hold_tag", res_tag, pt);
    end
    // behavioural divider: busy from the cycle after launch through the result pulse
    div_data_out_valid = 1'b0;
    div_busy = dv_act;
    if (dv_act) begin
      if (dv_cnt == 0) begin
        div_data_out_valid = 1'b1;
        div_error     = (dv_b == 0);
        div_quotient  = (dv_b == 0) ? '1 : dv_a / dv_b;
        div_remainder = (dv_b == 0) ? dv_a : dv_a % dv_b;
        dv_act = 0;
      end else dv_cnt--;
    end
    if (div_data_in_valid) begin
      dv_act = 1; dv_a = div_dividend; dv_b = div_divisor;
      dv_cnt = (force_lat > 0) ? force_lat : int'($urandom_range(0, 6));
    end
    prev_busy = div_busy;
    req_valid = v; req_dividend = a; req_divisor = b; res_ready = rr; rst = r;
    #1;
    if (r) chk("ready_in_rst", req_ready, 0);
    else   chk("req_ready", req_ready, fq.size() < DEPTH);
    fired = v && req_ready;
    if (fired) fq.push_back('{a: a, b: b, pstep: stepn});
    if (res_valid && !r) begin
      if (iq.size() == 0) chk("spurious_res", 1, 0);
      else if (rr) begin
        f = iq.pop_front();
        if (f.to || f.b == 0) begin eq = '0; er = '0; ee = 1'b1; end
        else begin eq = f.a / f.b; er = f.a % f.b; ee = 1'b0; end
        chk("res_q", res_quotient, eq);
        chk("res_r", res_remainder, er);
        chk("res_err", res_error, ee);
        chk("res_tag", res_tag, f.tag);
`ifdef DIV_DISPATCH_TIMEOUT_EN
        chk("res_timeout", res_timeout, f.to);
`endif
        last_q = res_quotient; last_r = res_remainder; last_e = res_error; last_tag = res_tag;
      end
    end
    prev_resv = res_valid;
    prev_hold = res_valid && !rr && !r;
    pq = res_quotient; pr = res_remainder; pe = res_error; pt = res_tag;
    if (r) begin
      fq.delete(); iq.delete(); mtag = '0; prev_hold = 0;
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input bit rr);
    int n = 0;
    do begin cyc(1, a, b, rr, 0); n++; end while (!fired && n < 200);
    if (!fired) chk("push_timeout", 0, 1);
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, rr, 0);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((fq.size() != 0 || iq.size() != 0) && n < maxc) begin cyc(0, '0, '0, 1, 0); n++; end
    chk("drain_done", fq.size() + iq.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc(0, '0, '0, 0, 1);
    cyc(0, '0, '0, 0, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_dv", div_data_in_valid, 0);
    chk("rst_res_q", res_quotient, 0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_count", fifo_count, 0);

    push(100, 7, 1); drain(100);
    chk("d100_7_q", last_q, 14); chk("d100_7_r", last_r, 2);
    chk("d100_7_e", last_e, 0);  chk("d100_7_tag", last_tag, 0);

    push(5, 0, 1); drain(100);
    chk("d5_0_q", last_q, 0); chk("d5_0_r", last_r, 0); chk("d5_0_e", last_e, 1);

    // hold a result, fill the FIFO behind it, then release
    push(9, 2, 0);
    begin
      int n = 0;
      while (!res_valid && n < 100) begin cyc(0, '0, '0, 0, 0); n++; end
      chk("hold_reached", res_valid, 1);
    end
    for (int i = 0; i < 4; i++) push(1000 + i, i + 1, 0);
    cyc(0, '0, '0, 0, 0);
    chk("full_ready", req_ready, 0);
    chk("full_count", fifo_count, 4);
    idle(20, 0);
    chk("held_count", fifo_count, 4);
    push(2000, 9, 1);
    drain(300);

    // long-latency op: watchdog fires only in the timeout build
    force_lat = 40;
    push(1000, 1, 1);
    begin
      int n = 0;
      while (iq.size() == 0 && n < 50) begin cyc(0, '0, '0, 1, 0); n++; end
    end
    force_lat = 0;
    drain(300);
    idle(50, 1);

    // reset in the middle of WAIT
    force_lat = 30;
    push(1000, 1, 1);
    begin
      int n = 0;
      while (iq.size() == 0 && n < 50) begin cyc(0, '0, '0, 1, 0); n++; end
      chk("rst_op_launched", iq.size(), 1);
    end
    idle(3, 1);
    force_lat = 0;
    cyc(0, '0, '0, 0, 1);
    cyc(0, '0, '0, 0, 1);
    cyc(0, '0, '0, 1, 0);
    chk("post_rst_count", fifo_count, 0);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_valid", res_valid, 0);
    push(7, 2, 1); drain(200);
    chk("post_rst_tag", last_tag, 0);
    chk("post_rst_q", last_q, 3);

    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = '0;
        1, 2, 3: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      cyc($urandom_range(0, 1), a, b, $urandom_range(0, 9) < 7, 0);
    end
    drain(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
